trees_host_sequencer: RTL and testbench

- Host-side driver for the random-forest inference engine's load/start/done interface.
- Takes a 64-bit valid/ready word stream from the DMA/host front end and optionally writes it into tree memory. Then writes the feature words, pulses start, waits for done and returns the prediction on a valid/ready result port.
- Sits between the accelerator's DMA wrapper and the trees engine instance.

---
 rtl/trees_pkg.sv | 35 +++
 rtl/trees_idx_counter.sv | 39 +++
 rtl/trees_host_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_trees_host_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trees_pkg.sv
// Shared types and width helpers for the random-forest host sequencer.
`default_nettype none

package trees_pkg;

  localparam int FEATS_PER_WORD = 2;

  // Index width for a range of n slots; a single slot still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a count that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int TREE_IDX_W  = idx_w(16);
  localparam int NODE_IDX_W  = idx_w(256);
  localparam int FEAT_WORD_W = idx_w(32 / FEATS_PER_WORD);
  localparam int CFG_TREES_W = cnt_w(16);
  localparam int CFG_NODES_W = cnt_w(256);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_TREES = 3'd1,
    ST_LOAD_FEATS = 3'd2,
    ST_START      = 3'd3,
    ST_WAIT       = 3'd4,
    ST_RESULT     = 3'd5
  } host_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/trees_idx_counter.sv
// Two-level index walker: inner advances fastest, outer steps when inner wraps.
`default_nettype none

module trees_idx_counter #(
  parameter int INNER_W = 1,
  parameter int OUTER_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [INNER_W-1:0] inner_max,
  input  logic [OUTER_W-1:0] outer_max,
  output logic [INNER_W-1:0] inner,
  output logic [OUTER_W-1:0] outer,
  output logic               last_inner,
  output logic               last_outer
);

  assign last_inner = (inner == inner_max);
  assign last_outer = (outer == outer_max);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      inner <= '0;
      outer <= '0;
    end else if (advance) begin
      if (last_inner) begin
        inner <= '0;
        outer <= last_outer ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/trees_host_sequencer.sv
// Host-side sequencer: streams trees and features into the engine, starts it,
// and returns the prediction (or an error) on a valid/ready result port.
`default_nettype none

module trees_host_sequencer
  import trees_pkg::*;
#(
  parameter int N_TREES          = 16,
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_start,
  input  logic [cnt_w(N_TREES)-1:0]           cfg_n_trees,
  input  logic [cnt_w(N_NODE_AND_LEAFS)-1:0]  cfg_n_nodes,
  input  logic                                in_valid,
  input  logic [63:0]                         in_data,
  output logic                                in_ready,
  output logic                                load_trees,
  output logic [idx_w(N_TREES)-1:0]           n_tree,
  output logic [idx_w(N_NODE_AND_LEAFS)-1:0]  n_node,
  output logic [63:0]                         tree_nodes,
  output logic                                load_features,
  output logic [31:0]                         n_feature,
  output logic [63:0]                         features2,
  output logic                                start,
  input  logic [31:0]                         prediction,
  input  logic                                done,
  output logic                                res_valid,
  output logic [31:0]                         res_data,
  output logic                                res_err,
  input  logic                                res_ready,
  output logic                                busy
);

  localparam int TREE_W = idx_w(N_TREES);
  localparam int NODE_W = idx_w(N_NODE_AND_LEAFS);
  localparam int FEAT_W = idx_w(N_FEATURE / FEATS_PER_WORD);
  localparam int CFGT_W = cnt_w(N_TREES);
  localparam int CFGN_W = cnt_w(N_NODE_AND_LEAFS);

  localparam logic [CFGT_W-1:0] MAX_TREES    = CFGT_W'(N_TREES);
  localparam logic [CFGN_W-1:0] MAX_NODES    = CFGN_W'(N_NODE_AND_LEAFS);
  localparam logic [FEAT_W-1:0] FEAT_LAST    = FEAT_W'(N_FEATURE / FEATS_PER_WORD - 1);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  host_seq_state_t state, state_next;

  logic [TREE_W-1:0] trees_last;
  logic [NODE_W-1:0] nodes_last;
  logic [TREE_W-1:0] tree_idx;
  logic [NODE_W-1:0] node_idx;
  logic [FEAT_W-1:0] feat_idx;
  logic              feat_outer_unused;
  logic              tree_last_node, tree_last_tree;
  logic              feat_last_inner, feat_last_outer;
  logic [31:0]       wait_cnt;

  logic idle, accept, tree_adv, feat_adv, cfg_bad, timeout_hit;

  assign idle     = (state == ST_IDLE);
  assign busy     = !idle;
  assign in_ready = (state == ST_LOAD_TREES) || (state == ST_LOAD_FEATS);
  assign accept   = in_valid && in_ready;
  assign tree_adv = accept && (state == ST_LOAD_TREES);
  assign feat_adv = accept && (state == ST_LOAD_FEATS);

  assign cfg_bad = (cfg_n_trees > MAX_TREES) ||
                   ((cfg_n_trees != '0) && ((cfg_n_nodes == '0) || (cfg_n_nodes > MAX_NODES)));

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_LAST);

  trees_idx_counter #(
    .INNER_W (NODE_W),
    .OUTER_W (TREE_W)
  ) u_tree_walk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (idle),
    .advance    (tree_adv),
    .inner_max  (nodes_last),
    .outer_max  (trees_last),
    .inner      (node_idx),
    .outer      (tree_idx),
    .last_inner (tree_last_node),
    .last_outer (tree_last_tree)
  );

  // Feature walk is a single row: outer limit of one.
  trees_idx_counter #(
    .INNER_W (FEAT_W),
    .OUTER_W (1)
  ) u_feat_walk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (idle),
    .advance    (feat_adv),
    .inner_max  (FEAT_LAST),
    .outer_max  (1'b0),
    .inner      (feat_idx),
    .outer      (feat_outer_unused),
    .last_inner (feat_last_inner),
    .last_outer (feat_last_outer)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          if (cfg_bad)                 state_next = ST_RESULT;
          else if (cfg_n_trees == '0)  state_next = ST_LOAD_FEATS;
          else                         state_next = ST_LOAD_TREES;
        end
      end
      ST_LOAD_TREES: if (tree_adv && tree_last_node && tree_last_tree) state_next = ST_LOAD_FEATS;
      ST_LOAD_FEATS: if (feat_adv && feat_last_inner && feat_last_outer) state_next = ST_START;
      ST_START:      state_next = ST_WAIT;
      ST_WAIT:       if (done || timeout_hit) state_next = ST_RESULT;
      ST_RESULT:     if (res_valid && res_ready) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_trees    <= 1'b0;
      n_tree        <= '0;
      n_node        <= '0;
      tree_nodes    <= '0;
      load_features <= 1'b0;
      n_feature     <= '0;
      features2     <= '0;
      start         <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_err       <= 1'b0;
      trees_last    <= '0;
      nodes_last    <= '0;
      wait_cnt      <= '0;
    end else begin
      load_trees    <= tree_adv;
      load_features <= feat_adv;
      start         <= (state == ST_START);
      wait_cnt      <= (state == ST_WAIT) ? wait_cnt + 32'd1 : 32'd0;

      if (idle && cmd_start) begin
        trees_last <= TREE_W'(cfg_n_trees - 1'b1);
        nodes_last <= NODE_W'(cfg_n_nodes - 1'b1);
      end

      if (tree_adv) begin
        n_tree     <= tree_idx;
        n_node     <= node_idx;
        tree_nodes <= in_data;
      end

      if (feat_adv) begin
        n_feature <= 32'({feat_idx, 1'b0});
        features2 <= in_data;
      end

      if (idle && cmd_start && cfg_bad) begin
        res_valid <= 1'b1;
        res_err   <= 1'b1;
        res_data  <= '0;
      end else if ((state == ST_WAIT) && done) begin
        res_valid <= 1'b1;
        res_err   <= 1'b0;
        res_data  <= prediction;
      end else if ((state == ST_WAIT) && timeout_hit) begin
        res_valid <= 1'b1;
        res_err   <= 1'b1;
        res_data  <= '0;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trees_host_sequencer.sv
// Self-checking bench for trees_host_sequencer with a small engine model.
`default_nettype none

module tb_trees_host_sequencer;

  localparam int N_TREES   = 2;
  localparam int N_NODES   = 4;
  localparam int N_FEATURE = 4;
  localparam int TIMEOUT   = 10;
  localparam int ENG_DELAY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [1:0]  cfg_n_trees = '0;
  logic [2:0]  cfg_n_nodes = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        load_trees;
  logic [0:0]  n_tree;
  logic [1:0]  n_node;
  logic [63:0] tree_nodes;
  logic        load_features;
  logic [31:0] n_feature;
  logic [63:0] features2;
  logic        start;
  logic [31:0] prediction = '0;
  logic        done;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_ready = 1'b0;
  logic        busy;

  logic eng_done = 1'b0;
  logic stray_done = 1'b0;
  assign done = eng_done | stray_done;

  trees_host_sequencer #(
    .N_TREES          (N_TREES),
    .N_NODE_AND_LEAFS (N_NODES),
    .N_FEATURE        (N_FEATURE),
    .TIMEOUT_CYCLES   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_start     (cmd_start),
    .cfg_n_trees   (cfg_n_trees),
    .cfg_n_nodes   (cfg_n_nodes),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .load_trees    (load_trees),
    .n_tree        (n_tree),
    .n_node        (n_node),
    .tree_nodes    (tree_nodes),
    .load_features (load_features),
    .n_feature     (n_feature),
    .features2     (features2),
    .start         (start),
    .prediction    (prediction),
    .done          (done),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_err       (res_err),
    .res_ready     (res_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Write monitor: records every strobe seen on the engine side.
  typedef struct { int t; int n; logic [63:0] d; } tw_t;
  typedef struct { logic [31:0] idx; logic [63:0] d; } fw_t;
  tw_t tq[$];
  fw_t fq[$];
  int start_cnt = 0, start_cyc = -1, last_feat_cyc = -1, ready_cnt = 0;

  always @(negedge clk) begin
    if (load_trees) tq.push_back('{int'(n_tree), int'(n_node), tree_nodes});
    if (load_features) begin
      fq.push_back('{n_feature, features2});
      last_feat_cyc = cyc;
    end
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (in_ready) ready_cnt++;
  end

  // Engine model: answers ENG_DELAY cycles after start when enabled.
  bit          eng_on = 1'b1;
  logic [31:0] eng_pred = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (start && eng_on) begin
        repeat (ENG_DELAY) @(posedge clk);
        #2;
        prediction = eng_pred;
        eng_done   = 1'b1;
        @(posedge clk);
        #2;
        eng_done   = 1'b0;
      end
    end
  end

  function automatic bit bad_cfg(input int t, input int n);
    return (t > N_TREES) || (t != 0 && (n == 0 || n > N_NODES));
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_flags"}, 64'({in_ready, load_trees, load_features, start, res_valid, res_err, busy, n_tree, n_node}), 64'd0);
    chk({tag, "_tree_nodes"}, tree_nodes, 64'd0);
    chk({tag, "_features2"}, features2, 64'd0);
    chk({tag, "_nfeat_resdata"}, {n_feature, res_data}, 64'd0);
  endtask

  task automatic run_job(input int t, input int n, input bit exp_bad, input bit gaps,
                         input int rdy_delay, input logic [31:0] pred,
                         input bit eng_en, input bit inject);
    logic [63:0] words[$];
    int          nbeats, idx, guard, cmd_cyc, res_cyc;
    logic [31:0] rd;
    logic        re;
    bit          exp_err;
    exp_err = exp_bad || !eng_en;
    nbeats  = exp_bad ? 0 : t * n + N_FEATURE / 2;
    for (int k = 0; k < nbeats; k++) words.push_back({$urandom, $urandom});
    tq.delete();
    fq.delete();
    start_cnt = 0; start_cyc = -1; last_feat_cyc = -1; ready_cnt = 0;
    eng_on = eng_en; eng_pred = pred;

    cfg_n_trees = 2'(t);
    cfg_n_nodes = 3'(n);
    cmd_start   = 1'b1;
    cmd_cyc     = cyc;
    tick();
    cmd_start   = 1'b0;

    idx = 0; guard = 0;
    while (idx < nbeats && guard < 1000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = words[idx];
      if (in_valid && in_ready) idx++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", 64'(idx), 64'(nbeats));

    guard = 0;
    while (!res_valid && guard < 200) begin
      if (inject && start) begin
        cfg_n_trees = 2'd1;
        cfg_n_nodes = 3'd1;
        cmd_start   = 1'b1;
        tick();
        cmd_start   = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    res_cyc = cyc;
    rd = res_data;
    re = res_err;
    chk("res_err", 64'(re), 64'(exp_err));
    chk("res_data", 64'(rd), exp_err ? 64'd0 : 64'(pred));

    if (exp_bad) begin
      chk("bad_latency", 64'(res_cyc - cmd_cyc), 64'd1);
      chk("bad_no_ready", 64'(ready_cnt), 64'd0);
    end else begin
      chk("done_to_res", 64'(res_cyc - start_cyc), eng_en ? 64'(ENG_DELAY + 1) : 64'(TIMEOUT));
      chk("start_after_feat", 64'(start_cyc - last_feat_cyc), 64'd1);
      if (!gaps && eng_en)
        chk("job_latency", 64'(res_cyc - cmd_cyc), 64'(1 + t * n + N_FEATURE / 2 + 1 + ENG_DELAY + 1));
    end

    for (int k = 0; k < rdy_delay; k++) begin
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(rd));
      chk("hold_err", 64'(res_err), 64'(re));
      chk("hold_busy", 64'(busy), 64'd1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_cleared", 64'(res_valid), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);

    chk("start_count", 64'(start_cnt), exp_bad ? 64'd0 : 64'd1);
    chk("tree_writes", 64'(tq.size()), exp_bad ? 64'd0 : 64'(t * n));
    for (int k = 0; k < tq.size() && k < t * n && !exp_bad; k++) begin
      chk("tree_idx", 64'(tq[k].t), 64'(k / n));
      chk("node_idx", 64'(tq[k].n), 64'(k % n));
      chk("node_data", tq[k].d, words[k]);
    end
    chk("feat_writes", 64'(fq.size()), exp_bad ? 64'd0 : 64'(N_FEATURE / 2));
    for (int k = 0; k < fq.size() && k < N_FEATURE / 2 && !exp_bad; k++) begin
      chk("feat_idx", 64'(fq[k].idx), 64'(2 * k));
      chk("feat_data", fq[k].d, words[t * n + k]);
    end
  endtask

  typedef struct { int t; int n; bit bad; } cfg_vec_t;
  cfg_vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, 4, 1'b0};
    vecs[1] = '{0, 0, 1'b0};
    vecs[2] = '{1, 5, 1'b1};
    vecs[3] = '{3, 1, 1'b1};
    vecs[4] = '{1, 0, 1'b1};
    vecs[5] = '{1, 1, 1'b0};
    vecs[6] = '{2, 3, 1'b0};
    vecs[7] = '{0, 7, 1'b0};

    // Reset with junk on the inputs.
    cmd_start = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    tick();
    check_outputs_zero("reset");
    cmd_start = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Full job: 2 trees x 4 nodes, no stalls, engine returns 3.
    run_job(2, 4, 1'b0, 1'b0, 0, 32'd3, 1'b1, 1'b0);

    // Configuration table.
    for (int i = 0; i < 8; i++)
      run_job(vecs[i].t, vecs[i].n, vecs[i].bad, 1'b0, 1, $urandom, 1'b1, 1'b0);

    // Stream gaps and result back-pressure.
    run_job(2, 4, 1'b0, 1'b1, 5, 32'hFFFF_FFF9, 1'b1, 1'b0);

    // Engine never answers: timeout, then a stray done in IDLE.
    run_job(1, 1, 1'b0, 1'b0, 2, 32'd0, 1'b0, 1'b0);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stray_done_valid", 64'(res_valid), 64'd0);
      chk("stray_done_busy", 64'(busy), 64'd0);
      tick();
    end

    // Reset three beats into a tree load.
    cfg_n_trees = 2'd2; cfg_n_nodes = 3'd4; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_outputs_zero("midjob_reset");
    rst_n = 1'b1;
    tick();
    run_job(2, 4, 1'b0, 1'b0, 0, 32'd42, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("no_restart_busy", 64'(busy), 64'd0);
      tick();
    end

    // Randomised jobs against the reference model.
    for (int i = 0; i < 12; i++) begin
      int t, n;
      if ($urandom_range(0, 3) == 0) begin
        t = $urandom_range(0, 3);
        n = $urandom_range(0, 7);
      end else begin
        t = $urandom_range(0, N_TREES);
        n = $urandom_range(1, N_NODES);
      end
      run_job(t, n, bad_cfg(t, n), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
